array_ctrl: RTL

Request front-end for the 4-entry × 16-bit register array. It accepts read/write commands over a valid/ready interface, buffers them in a small in-order FIFO and drives the array's `sel`/`wr`/`addr`/`wdata` pins one command at a time. It captures the array's registered `rdata` and returns it on a valid/ready response channel. The block sits directly upstream of the array and is its only master.

---
 rtl/array_ctrl_pkg.sv | 21 ++
 rtl/array_ctrl_if.sv | 28 ++
 rtl/array_ctrl_req_fifo.sv | 46 ++++
 rtl/array_ctrl.sv | 124 ++++++++++++
 4 files changed

// File: rtl/array_ctrl_pkg.sv
// Shared definitions for the array request front-end: default widths,
// controller state encodings and the packed FIFO entry width.
package array_ctrl_pkg;

   localparam int DEF_ADDR_W = 2;
   localparam int DEF_DATA_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_WR   = 3'd1,
      ST_RD   = 3'd2,
      ST_CAP  = 3'd3,
      ST_RESP = 3'd4
   } ctrlState_t;

   // A queued command is packed as {wr, addr, wdata}.
   function automatic int entryWidth(input int addrW, input int dataW);
      return 1 + addrW + dataW;
   endfunction

endpackage

// File: rtl/array_ctrl_if.sv
// Request and response valid/ready channels between a command source
// (master) and the array front-end (slave).
interface array_ctrl_if
   import array_ctrl_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
);
   logic              req_valid;
   logic              req_ready;
   logic              req_wr;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [ADDR_W-1:0] rsp_addr;
   logic [DATA_W-1:0] rsp_rdata;

   modport master (
      output req_valid, req_wr, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_addr, rsp_rdata
   );

   modport slave (
      input  req_valid, req_wr, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_addr, rsp_rdata
   );
endinterface

// File: rtl/array_ctrl_req_fifo.sv
// In-order command FIFO; pointers carry one extra wrap bit so that
// full and empty are distinguishable when the indices coincide.
module req_fifo #(
   parameter int WIDTH = 19,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_pushData,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_popData,
   output logic             o_full,
   output logic             o_empty
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_doPush;
   logic             w_doPop;

   assign o_empty   = (r_wrPtr == r_rdPtr);
   assign o_full    = (r_wrPtr[IDX_W] != r_rdPtr[IDX_W]) &&
                      (r_wrPtr[IDX_W-1:0] == r_rdPtr[IDX_W-1:0]);
   assign w_doPush  = i_push && !o_full;
   assign w_doPop   = i_pop && !o_empty;
   assign o_popData = r_mem[r_rdPtr[IDX_W-1:0]];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
      end else begin
         if (w_doPush) r_wrPtr <= r_wrPtr + PTR_W'(1);
         if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
   end

   // Storage needs no reset: an entry is only read after it was pushed.
   always_ff @(posedge clk) begin
      if (w_doPush) r_mem[r_wrPtr[IDX_W-1:0]] <= i_pushData;
   end
endmodule

// File: rtl/array_ctrl.sv
// Front-end for the register array: queues commands, drives the array
// pins one command at a time and returns read data on the response channel.
module array_ctrl
   import array_ctrl_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst,
   array_ctrl_if.slave       bus,
   output logic              o_arrSel,
   output logic              o_arrWr,
   output logic [ADDR_W-1:0] o_arrAddr,
   output logic [DATA_W-1:0] o_arrWdata,
   input  logic [DATA_W-1:0] i_arrRdata,
   output logic              o_busy
);
   localparam int ENTRY_W = entryWidth(ADDR_W, DATA_W);

   logic [ENTRY_W-1:0] w_pushData;
   logic [ENTRY_W-1:0] w_head;
   logic               w_full;
   logic               w_empty;
   logic               w_pop;
   logic               w_headWr;
   logic [ADDR_W-1:0]  w_headAddr;
   logic [DATA_W-1:0]  w_headWdata;

   ctrlState_t         r_state;
   logic               r_arrSel;
   logic               r_arrWr;
   logic [ADDR_W-1:0]  r_arrAddr;
   logic [DATA_W-1:0]  r_arrWdata;
   logic               r_rspValid;
   logic [ADDR_W-1:0]  r_rspAddr;
   logic [DATA_W-1:0]  r_rspRdata;

   assign w_pushData = {bus.req_wr, bus.req_addr, bus.req_wdata};
   assign w_pop      = (r_state == ST_IDLE) && !w_empty;
   assign {w_headWr, w_headAddr, w_headWdata} = w_head;

   req_fifo #(.WIDTH(ENTRY_W), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .i_push    (bus.req_valid),
      .i_pushData(w_pushData),
      .i_pop     (w_pop),
      .o_popData (w_head),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

   // Space freed by a pop only becomes visible the cycle after.
   assign bus.req_ready = !w_full;
   assign o_busy        = !w_empty || (r_state != ST_IDLE);

   assign o_arrSel      = r_arrSel;
   assign o_arrWr       = r_arrWr;
   assign o_arrAddr     = r_arrAddr;
   assign o_arrWdata    = r_arrWdata;
   assign bus.rsp_valid = r_rspValid;
   assign bus.rsp_addr  = r_rspAddr;
   assign bus.rsp_rdata = r_rspRdata;

   // Each command holds the array select for exactly one cycle; reads then
   // wait one cycle for the array's registered data before capturing it.
   // Write data is only reloaded by writes so the pins stay quiet on reads.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= ST_IDLE;
         r_arrSel   <= 1'b0;
         r_arrWr    <= 1'b0;
         r_arrAddr  <= '0;
         r_arrWdata <= '0;
         r_rspValid <= 1'b0;
         r_rspAddr  <= '0;
         r_rspRdata <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (!w_empty) begin
                  r_arrSel  <= 1'b1;
                  r_arrWr   <= w_headWr;
                  r_arrAddr <= w_headAddr;
                  if (w_headWr) r_arrWdata <= w_headWdata;
                  r_state   <= w_headWr ? ST_WR : ST_RD;
               end else begin
                  r_arrSel <= 1'b0;
                  r_arrWr  <= 1'b0;
               end
            end
            ST_WR: begin
               r_arrSel <= 1'b0;
               r_arrWr  <= 1'b0;
               r_state  <= ST_IDLE;
            end
            ST_RD: begin
               r_arrSel <= 1'b0;
               r_arrWr  <= 1'b0;
               r_state  <= ST_CAP;
            end
            ST_CAP: begin
               r_rspRdata <= i_arrRdata;
               r_rspAddr  <= r_arrAddr;
               r_rspValid <= 1'b1;
               r_state    <= ST_RESP;
            end
            ST_RESP: begin
               if (bus.rsp_ready) begin
                  r_rspValid <= 1'b0;
                  r_state    <= ST_IDLE;
               end
            end
            default: begin
               r_arrSel <= 1'b0;
               r_arrWr  <= 1'b0;
               r_state  <= ST_IDLE;
            end
         endcase
      end
   end
endmodule
